id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_pkg.sv | 57 +++++
 rtl/alu_ctrl_dec.sv | 68 ++++++
 rtl/id_ex_stage.sv | 103 ++++++++++
 tb/tb_id_ex_stage.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_pkg.sv
// Shared ALU select codes, MIPS opcode/funct values and the decoded control bundle.
// Used by the decoder and the ID/EX register stage.
package id_ex_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_MULT = 4'b0010;
    localparam logic [3:0] ALU_DIV  = 4'b0011;
    localparam logic [3:0] ALU_AND  = 4'b0100;
    localparam logic [3:0] ALU_OR   = 4'b0101;
    localparam logic [3:0] ALU_NOR  = 4'b0110;
    localparam logic [3:0] ALU_NOP  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1001;
    localparam logic [3:0] ALU_XOR  = 4'b1010;
    localparam logic [3:0] ALU_SLTI = 4'b1011;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    // IMM_NONE selects the rt register value as the y operand
    typedef enum logic [1:0] {
        IMM_NONE = 2'd0,
        IMM_SEXT = 2'd1,
        IMM_ZEXT = 2'd2
    } imm_mode_t;

    typedef struct packed {
        logic [3:0] alu_sel;
        imm_mode_t  imm_mode;
        logic       dest_rd;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational MIPS decoder: instruction word -> ALU select, immediate mode, control bits.
// Zero latency; no flow control of its own.
// Backpressure: none, purely combinational.
module alu_ctrl_dec
    import id_ex_pkg::*;
(
    input  logic [31:0] instr,
    output ctrl_t       ctrl
);

    logic [5:0] opcode;
    logic [5:0] funct;

    assign opcode = instr[31:26];
    assign funct  = instr[5:0];

    always_comb begin
        ctrl          = '0;
        ctrl.alu_sel  = ALU_NOP;
        ctrl.imm_mode = IMM_NONE;
        case (opcode)
            OP_RTYPE: begin
                ctrl.dest_rd   = 1'b1;
                ctrl.reg_write = 1'b1;
                case (funct)
                    FN_ADD, FN_ADDU: ctrl.alu_sel = ALU_ADD;
                    FN_SUB, FN_SUBU: ctrl.alu_sel = ALU_SUB;
                    FN_MULT:         ctrl.alu_sel = ALU_MULT;
                    FN_DIV:          ctrl.alu_sel = ALU_DIV;
                    FN_AND:          ctrl.alu_sel = ALU_AND;
                    FN_OR:           ctrl.alu_sel = ALU_OR;
                    FN_NOR:          ctrl.alu_sel = ALU_NOR;
                    FN_SLT:          ctrl.alu_sel = ALU_SLT;
                    FN_XOR:          ctrl.alu_sel = ALU_XOR;
                    default: begin
                        ctrl.reg_write = 1'b0;
                        ctrl.illegal   = 1'b1;
                    end
                endcase
            end
            OP_ADDI, OP_ADDIU: begin
                ctrl.alu_sel = ALU_ADD;  ctrl.imm_mode = IMM_SEXT; ctrl.reg_write = 1'b1;
            end
            OP_SLTI: begin
                ctrl.alu_sel = ALU_SLTI; ctrl.imm_mode = IMM_SEXT; ctrl.reg_write = 1'b1;
            end
            OP_ANDI: begin
                ctrl.alu_sel = ALU_AND;  ctrl.imm_mode = IMM_ZEXT; ctrl.reg_write = 1'b1;
            end
            OP_ORI: begin
                ctrl.alu_sel = ALU_OR;   ctrl.imm_mode = IMM_ZEXT; ctrl.reg_write = 1'b1;
            end
            OP_XORI: begin
                ctrl.alu_sel = ALU_XOR;  ctrl.imm_mode = IMM_ZEXT; ctrl.reg_write = 1'b1;
            end
            OP_LW: begin
                ctrl.alu_sel = ALU_ADD;  ctrl.imm_mode = IMM_SEXT;
                ctrl.reg_write = 1'b1;   ctrl.mem_read = 1'b1;
            end
            OP_SW: begin
                ctrl.alu_sel = ALU_ADD;  ctrl.imm_mode = IMM_SEXT; ctrl.mem_write = 1'b1;
            end
            OP_BEQ:  ctrl.alu_sel = ALU_SUB;
            default: ctrl.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: decodes, selects operands and holds one bundle for the ALU.
// Latency 1 cycle; full throughput, consume and accept in one cycle swap without a bubble.
// Backpressure: in_ready = !out_valid || out_ready, gated by reset and flush. ALU_FWD_EN adds operand forwarding.
module id_ex_stage
    import id_ex_pkg::*;
#(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   instr,
    input  logic [DW-1:0] rs_data,
    input  logic [DW-1:0] rt_data,
`ifdef ALU_FWD_EN
    input  logic          fwd_valid,
    input  logic [RW-1:0] fwd_dest,
    input  logic [DW-1:0] fwd_data,
`endif
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [3:0]    alu_sel,
    output logic [DW-1:0] op_a,
    output logic [DW-1:0] op_b,
    output logic [DW-1:0] st_data,
    output logic [RW-1:0] dest,
    output logic          reg_write,
    output logic          mem_read,
    output logic          mem_write,
    output logic          illegal
);

    ctrl_t         ctrl;
    logic [RW-1:0] rs_idx, rt_idx, rd_idx, dest_nxt;
    logic [DW-1:0] rs_val, rt_val, op_b_nxt;
    logic          accept;

    alu_ctrl_dec u_dec (
        .instr (instr),
        .ctrl  (ctrl)
    );

    assign rs_idx = RW'(instr[25:21]);
    assign rt_idx = RW'(instr[20:16]);
    assign rd_idx = RW'(instr[15:11]);

`ifdef ALU_FWD_EN
    assign rs_val = (fwd_valid && fwd_dest != '0 && fwd_dest == rs_idx) ? fwd_data : rs_data;
    assign rt_val = (fwd_valid && fwd_dest != '0 && fwd_dest == rt_idx) ? fwd_data : rt_data;
`else
    assign rs_val = rs_data;
    assign rt_val = rt_data;
`endif

    assign dest_nxt = ctrl.dest_rd ? rd_idx : rt_idx;

    always_comb begin
        op_b_nxt = rt_val;
        case (ctrl.imm_mode)
            IMM_SEXT: op_b_nxt = {{(DW-16){instr[15]}}, instr[15:0]};
            IMM_ZEXT: op_b_nxt = {{(DW-16){1'b0}}, instr[15:0]};
            default:  op_b_nxt = rt_val;
        endcase
    end

    // Flush refuses the incoming word as well as killing the held one
    assign in_ready = rst_n && !flush && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            alu_sel   <= ALU_NOP;
            op_a      <= '0;
            op_b      <= '0;
            st_data   <= '0;
            dest      <= '0;
            reg_write <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            illegal   <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            alu_sel   <= ctrl.alu_sel;
            op_a      <= rs_val;
            op_b      <= op_b_nxt;
            st_data   <= rt_val;
            dest      <= dest_nxt;
            reg_write <= ctrl.reg_write && (dest_nxt != '0);
            mem_read  <= ctrl.mem_read;
            mem_write <= ctrl.mem_write;
            illegal   <= ctrl.illegal;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed scenarios followed by random traffic, checked against a behavioural model of the stage.
module tb_id_ex_stage;

    localparam int DW = 32;
    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          rst_n, in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0]   instr;
    logic [DW-1:0] rs_data, rt_data, op_a, op_b, st_data;
    logic [3:0]    alu_sel;
    logic [RW-1:0] dest;
    logic          reg_write, mem_read, mem_write, illegal;
`ifdef ALU_FWD_EN
    logic          fwd_valid;
    logic [RW-1:0] fwd_dest;
    logic [DW-1:0] fwd_data;
`endif

    always #5 clk = ~clk;

    id_ex_stage #(.DW(DW), .RW(RW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .rs_data   (rs_data),
        .rt_data   (rt_data),
`ifdef ALU_FWD_EN
        .fwd_valid (fwd_valid),
        .fwd_dest  (fwd_dest),
        .fwd_data  (fwd_data),
`endif
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_sel   (alu_sel),
        .op_a      (op_a),
        .op_b      (op_b),
        .st_data   (st_data),
        .dest      (dest),
        .reg_write (reg_write),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .illegal   (illegal)
    );

    typedef struct {
        logic [3:0]  alu;
        logic [31:0] a, b, st;
        logic [4:0]  dest;
        logic        rw, mr, mw, ill;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    exp_t m;
    logic m_valid;

    localparam logic [5:0] LEGAL_FN [10] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h18, 6'h1A, 6'h24, 6'h25, 6'h27, 6'h2A};
    localparam logic [5:0] ANY_OP   [12] = '{6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h23, 6'h2B, 6'h04, 6'h3F, 6'h02, 6'h26};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t reset_bundle();
        exp_t e;
        e.alu = 4'b0111; e.a = '0; e.b = '0; e.st = '0; e.dest = '0;
        e.rw = 1'b0; e.mr = 1'b0; e.mw = 1'b0; e.ill = 1'b0;
        return e;
    endfunction

    // Expected bundle from the instruction set table, written as plain lookup
    function automatic exp_t ref_bundle(input logic [31:0] ins, input logic [31:0] rsv, input logic [31:0] rtv);
        exp_t        e;
        logic [5:0]  op, fn;
        logic [31:0] se, ze;
        op = ins[31:26];
        fn = ins[5:0];
        se = {{16{ins[15]}}, ins[15:0]};
        ze = {16'h0000, ins[15:0]};
        e.a = rsv; e.b = rtv; e.st = rtv; e.alu = 4'b0111;
        e.rw = 1'b0; e.mr = 1'b0; e.mw = 1'b0; e.ill = 1'b0;
        e.dest = (op == 6'h00) ? ins[15:11] : ins[20:16];
        case (op)
            6'h00: begin
                e.rw = 1'b1;
                case (fn)
                    6'h20, 6'h21: e.alu = 4'b0000;
                    6'h22, 6'h23: e.alu = 4'b0001;
                    6'h18:        e.alu = 4'b0010;
                    6'h1A:        e.alu = 4'b0011;
                    6'h24:        e.alu = 4'b0100;
                    6'h25:        e.alu = 4'b0101;
                    6'h27:        e.alu = 4'b0110;
                    6'h2A:        e.alu = 4'b1001;
                    6'h26:        e.alu = 4'b1010;
                    default: begin e.rw = 1'b0; e.ill = 1'b1; end
                endcase
            end
            6'h08, 6'h09: begin e.alu = 4'b0000; e.b = se; e.rw = 1'b1; end
            6'h0A:        begin e.alu = 4'b1011; e.b = se; e.rw = 1'b1; end
            6'h0C:        begin e.alu = 4'b0100; e.b = ze; e.rw = 1'b1; end
            6'h0D:        begin e.alu = 4'b0101; e.b = ze; e.rw = 1'b1; end
            6'h0E:        begin e.alu = 4'b1010; e.b = ze; e.rw = 1'b1; end
            6'h23:        begin e.alu = 4'b0000; e.b = se; e.rw = 1'b1; e.mr = 1'b1; end
            6'h2B:        begin e.alu = 4'b0000; e.b = se; e.mw = 1'b1; end
            6'h04:        e.alu = 4'b0001;
            default:      e.ill = 1'b1;
        endcase
        if (e.dest == 5'd0) e.rw = 1'b0;
        return e;
    endfunction

    function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // One clock: check in_ready, advance the model, then compare every output
    task automatic cycle();
        logic        rdy;
        logic [31:0] rsv, rtv;
        exp_t        nb;
        #1;
        rdy = rst_n && !flush && (!m_valid || out_ready);
        chk("in_ready", 32'(in_ready), 32'(rdy));
        rsv = rs_data;
        rtv = rt_data;
`ifdef ALU_FWD_EN
        if (fwd_valid && fwd_dest != 5'd0 && fwd_dest == instr[25:21]) rsv = fwd_data;
        if (fwd_valid && fwd_dest != 5'd0 && fwd_dest == instr[20:16]) rtv = fwd_data;
`endif
        nb = ref_bundle(instr, rsv, rtv);
        @(posedge clk);
        if (!rst_n) begin
            m_valid = 1'b0;
            m = reset_bundle();
        end else if (flush) begin
            m_valid = 1'b0;
        end else if (in_valid && rdy) begin
            m_valid = 1'b1;
            m = nb;
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
        #1;
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("alu_sel",   32'(alu_sel),   32'(m.alu));
        chk("op_a",      op_a,           m.a);
        chk("op_b",      op_b,           m.b);
        chk("st_data",   st_data,        m.st);
        chk("dest",      32'(dest),      32'(m.dest));
        chk("reg_write", 32'(reg_write), 32'(m.rw));
        chk("mem_read",  32'(mem_read),  32'(m.mr));
        chk("mem_write", 32'(mem_write), 32'(m.mw));
        chk("illegal",   32'(illegal),   32'(m.ill));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] held_a;
        m_valid   = 1'b0;
        m         = reset_bundle();
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        flush     = 1'b0;
        instr     = rtype(5'd8, 5'd9, 5'd10, 6'h22);
        rs_data   = 32'd7;
        rt_data   = 32'd3;
`ifdef ALU_FWD_EN
        fwd_valid = 1'b0;
        fwd_dest  = '0;
        fwd_data  = '0;
`endif

        // reset held two cycles with a request pending
        cycle();
        cycle();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_alu_sel",   32'(alu_sel),   32'b0111);
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        rst_n = 1'b1;

        // sub t2,t0,t1
        instr = 32'h01095022;
        cycle();
        chk("sub_alu", 32'(alu_sel), 32'b0001);
        chk("sub_a",   op_a,         32'd7);
        chk("sub_b",   op_b,         32'd3);
        chk("sub_dst", 32'(dest),    32'd10);
        chk("sub_rw",  32'(reg_write), 32'd1);

        instr = itype(6'h08, 5'd8, 5'd9, 16'hFFFC);
        cycle();
        chk("addi_sext", op_b, 32'hFFFFFFFC);
        instr = itype(6'h0D, 5'd8, 5'd9, 16'hFFFC);
        cycle();
        chk("ori_zext", op_b, 32'h0000FFFC);
        chk("ori_alu",  32'(alu_sel), 32'b0101);

        // backpressure: A held for three cycles while B waits
        instr = rtype(5'd1, 5'd2, 5'd3, 6'h20); rs_data = 32'hA0; rt_data = 32'hA1;
        cycle();
        held_a    = 32'hA0;
        out_ready = 1'b0;
        instr     = rtype(5'd4, 5'd5, 5'd6, 6'h25); rs_data = 32'hB0; rt_data = 32'hB1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("bp_hold_a",  op_a,          held_a);
            chk("bp_ready",   32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        cycle();
        chk("bp_swap_a",   op_a,           32'hB0);
        chk("bp_swap_vld", 32'(out_valid), 32'd1);

        // flush with a held bundle and a new request
        out_ready = 1'b0;
        flush     = 1'b1;
        instr     = rtype(5'd7, 5'd8, 5'd9, 6'h24);
        cycle();
        chk("flush_vld", 32'(out_valid), 32'd0);
        flush     = 1'b0;
        out_ready = 1'b1;

        instr = itype(6'h3F, 5'd3, 5'd4, 16'h1234);
        cycle();
        chk("ill_flag", 32'(illegal),   32'd1);
        chk("ill_alu",  32'(alu_sel),   32'b0111);
        chk("ill_vld",  32'(out_valid), 32'd1);
        chk("ill_rw",   32'(reg_write), 32'd0);

`ifdef ALU_FWD_EN
        fwd_valid = 1'b1; fwd_dest = 5'd8; fwd_data = 32'h55;
        instr = itype(6'h08, 5'd8, 5'd9, 16'h0001); rs_data = 32'h11;
        cycle();
        chk("fwd_a", op_a, 32'h55);
        fwd_dest = 5'd0;
        instr = itype(6'h08, 5'd0, 5'd9, 16'h0001);
        cycle();
        chk("fwd_zero", op_a, 32'h11);
        fwd_valid = 1'b0;
`endif

        // random traffic
        for (int n = 0; n < 600; n++) begin
            logic [4:0] rs, rt, rd;
            rs = 5'($urandom_range(0, 31));
            rt = 5'($urandom_range(0, 31));
            rd = 5'($urandom_range(0, 31));
            case ($urandom_range(0, 3))
                0, 1: instr = rtype(rs, rt, rd, LEGAL_FN[$urandom_range(0, 9)]);
                2:    instr = itype(ANY_OP[$urandom_range(0, 11)], rs, rt, 16'($urandom));
                default: instr = ($urandom_range(0, 1) == 0) ? rtype(rs, rt, rd, 6'h01)
                                                                : rtype(rs, rt, rd, 6'h26);
            endcase
            rs_data   = $urandom;
            rt_data   = $urandom;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            rst_n     = ($urandom_range(0, 63) != 0);
`ifdef ALU_FWD_EN
            fwd_valid = ($urandom_range(0, 1) == 0);
            fwd_dest  = ($urandom_range(0, 1) == 0) ? rs : 5'($urandom_range(0, 31));
            fwd_data  = $urandom;
`endif
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
